// File: rtl/ysyx_22040127_div_pkg.sv
// Shared encodings and helpers for the divide controller and its radix-2 divider.
package ysyx_22040127_div_pkg;

    // Divide op encoding, taken directly from funct3[1:0]
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DONE  = 2'b10,
        DRAIN = 2'b11
    } div_state_e;

    // Most negative dividend for the 64-bit and the sign-extended 32-bit forms
    localparam logic [63:0] MOST_NEG64    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MOST_NEG32_SX = 64'hFFFF_FFFF_8000_0000;

    // Sign-extend a 32-bit value to 64 bits
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Two's complement negation
    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/ysyx_22040127_div.sv
// Iterative radix-2 restoring divider. A one-cycle is_div pulse loads the
// magnitudes, 64 shift/subtract steps follow, then a sign-fix step re-reads the
// operand signs from div_x/div_y/div_s and raises ready for one cycle.
module ysyx_22040127_div
    import ysyx_22040127_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        is_div,
    input  logic [63:0] div_x,
    input  logic [63:0] div_y,
    input  logic        div_s,
    output logic        ready,
    output logic [63:0] quo,
    output logic [63:0] rem
);

    logic        run_r;
    logic        fix_r;
    logic [5:0]  cnt_r;
    logic [63:0] rem_acc_r;
    logic [63:0] quo_acc_r;
    logic [63:0] dvs_r;
    logic        ready_r;
    logic [63:0] quo_r;
    logic [63:0] rem_r;

    logic [63:0] abs_x_s;
    logic [63:0] abs_y_s;
    logic [64:0] rem_sh_s;
    logic [63:0] diff_s;
    logic        ge_s;
    logic [63:0] rem_nx_s;
    logic [63:0] quo_nx_s;
    logic        neg_q_s;
    logic        neg_r_s;

    // Operand magnitudes, one shift/subtract step, and result sign selection
    always_comb begin
        abs_x_s  = (div_s & div_x[63]) ? neg64(div_x) : div_x;
        abs_y_s  = (div_s & div_y[63]) ? neg64(div_y) : div_y;
        rem_sh_s = {rem_acc_r, quo_acc_r[63]};
        ge_s     = (rem_sh_s >= {1'b0, dvs_r});
        // When ge_s holds the true difference is below 2^64, so 64-bit wrap is exact
        diff_s   = rem_sh_s[63:0] - dvs_r;
        if (ge_s) begin
            rem_nx_s = diff_s;
        end else begin
            rem_nx_s = rem_sh_s[63:0];
        end
        quo_nx_s = {quo_acc_r[62:0], ge_s};
        neg_q_s  = div_s & (div_x[63] ^ div_y[63]);
        neg_r_s  = div_s & div_x[63];
    end

    // Load / iterate / sign-fix sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            run_r     <= 1'b0;
            fix_r     <= 1'b0;
            cnt_r     <= 6'd0;
            rem_acc_r <= 64'd0;
            quo_acc_r <= 64'd0;
            dvs_r     <= 64'd0;
            ready_r   <= 1'b0;
            quo_r     <= 64'd0;
            rem_r     <= 64'd0;
        end else begin
            ready_r <= 1'b0;
            if (run_r) begin
                rem_acc_r <= rem_nx_s;
                quo_acc_r <= quo_nx_s;
                cnt_r     <= cnt_r + 6'd1;
                if (cnt_r == 6'd63) begin
                    run_r <= 1'b0;
                    fix_r <= 1'b1;
                end else begin
                    run_r <= 1'b1;
                end
            end else if (fix_r) begin
                fix_r   <= 1'b0;
                ready_r <= 1'b1;
                quo_r   <= neg_q_s ? neg64(quo_acc_r) : quo_acc_r;
                rem_r   <= neg_r_s ? neg64(rem_acc_r) : rem_acc_r;
            end else if (is_div) begin
                run_r     <= 1'b1;
                cnt_r     <= 6'd0;
                rem_acc_r <= 64'd0;
                quo_acc_r <= abs_x_s;
                dvs_r     <= abs_y_s;
            end else begin
                run_r <= 1'b0;
            end
        end
    end

    assign ready = ready_r;
    assign quo   = quo_r;
    assign rem   = rem_r;

endmodule

// File: rtl/ysyx_22040127_div_ctrl.sv
// Sequencing controller between EX and the radix-2 divider: operand prep,
// divide-by-zero / overflow short-cuts, result selection and flush draining.
module ysyx_22040127_div_ctrl
    import ysyx_22040127_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    div_state_e  state_r;
    logic        busy_r;
    logic        resp_valid_r;
    logic [63:0] resp_data_r;
    logic        div_start_r;
    logic [63:0] a_r;
    logic [63:0] b_r;
    div_op_e     op_r;
    logic        word_r;

    logic        div_ready_s;
    logic [63:0] div_quo_s;
    logic [63:0] div_rem_s;

    logic        signed_s;
    logic [63:0] a_prep_s;
    logic [63:0] b_prep_s;
    logic [63:0] most_neg_s;
    logic        dbz_s;
    logic        ovf_s;
    logic        special_s;
    logic [63:0] sp_sel_s;
    logic [63:0] sp_res_s;
    logic        accept_s;
    logic [63:0] dv_sel_s;
    logic [63:0] dv_res_s;

    // Operand prep, special-case detection and result formatting
    always_comb begin
        signed_s = ~req_op[0];
        if (req_word) begin
            if (signed_s) begin
                a_prep_s = sext32(req_a[31:0]);
                b_prep_s = sext32(req_b[31:0]);
            end else begin
                a_prep_s = {32'd0, req_a[31:0]};
                b_prep_s = {32'd0, req_b[31:0]};
            end
        end else begin
            a_prep_s = req_a;
            b_prep_s = req_b;
        end
        most_neg_s = req_word ? MOST_NEG32_SX : MOST_NEG64;
        dbz_s      = (b_prep_s == 64'd0);
        ovf_s      = signed_s & (b_prep_s == 64'hFFFF_FFFF_FFFF_FFFF) & (a_prep_s == most_neg_s);
        special_s  = dbz_s | ovf_s;
        // rem flavour picks the remainder: a on divide-by-zero, 0 on overflow
        if (req_op[1]) begin
            sp_sel_s = dbz_s ? a_prep_s : 64'd0;
        end else begin
            sp_sel_s = dbz_s ? 64'hFFFF_FFFF_FFFF_FFFF : a_prep_s;
        end
        sp_res_s = req_word ? sext32(sp_sel_s[31:0]) : sp_sel_s;
        accept_s = req_valid & (state_r == IDLE) & ~flush;
        dv_sel_s = op_r[1] ? div_rem_s : div_quo_s;
        dv_res_s = word_r ? sext32(dv_sel_s[31:0]) : dv_sel_s;
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 64'd0;
            div_start_r  <= 1'b0;
            a_r          <= 64'd0;
            b_r          <= 64'd0;
            op_r         <= DIV_OP_DIV;
            word_r       <= 1'b0;
        end else begin
            div_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r    <= a_prep_s;
                        b_r    <= b_prep_s;
                        op_r   <= div_op_e'(req_op);
                        word_r <= req_word;
                        busy_r <= 1'b1;
                        if (special_s) begin
                            state_r      <= DONE;
                            resp_valid_r <= 1'b1;
                            resp_data_r  <= sp_res_s;
                        end else begin
                            state_r     <= RUN;
                            div_start_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (div_ready_s) begin
                        if (flush) begin
                            // Divider has just finished, so nothing is left to drain
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r      <= DONE;
                            resp_valid_r <= 1'b1;
                            resp_data_r  <= dv_res_s;
                        end
                    end else if (flush) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (flush || resp_ready) begin
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        resp_valid_r <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                DRAIN: begin
                    if (div_ready_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Operands stay in a_r/b_r/op_r until the next accept, which cannot
    // happen before the divider's ready pulse.
    ysyx_22040127_div u_div (
        .clk    (clk),
        .rst    (rst),
        .is_div (div_start_r),
        .div_x  (a_r),
        .div_y  (b_r),
        .div_s  (~op_r[0]),
        .ready  (div_ready_s),
        .quo    (div_quo_s),
        .rem    (div_rem_s)
    );

    assign req_ready  = (state_r == IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_ysyx_22040127_div_ctrl.sv
// Self-checking bench for the divide controller: directed cases plus
// randomized ops checked against an arithmetic reference model.
module tb_ysyx_22040127_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        req_word = 1'b0;
    logic [63:0] req_a = 64'd0;
    logic [63:0] req_b = 64'd0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int starts_total = 0;

    ysyx_22040127_div_ctrl #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_word   (req_word),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Count divider start pulses
    always @(posedge clk) begin
        if (dut.div_start_r) starts_total = starts_total + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M divide semantics, computed with plain arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b,
                                              output logic special);
        logic        sgn;
        logic [31:0] a32, b32, q32, r32, s32;
        logic [63:0] q64, r64;
        sgn = ~op[0];
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            special = 1'b0;
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; special = 1'b1;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; special = 1'b1;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            s32 = op[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end else begin
            special = 1'b0;
            if (b == 64'd0) begin
                q64 = 64'hFFFF_FFFF_FFFF_FFFF; r64 = a; special = 1'b1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q64 = a; r64 = 64'd0; special = 1'b1;
            end else if (sgn) begin
                q64 = $signed(a) / $signed(b);
                r64 = $signed(a) % $signed(b);
            end else begin
                q64 = a / b;
                r64 = a % b;
            end
            return op[1] ? r64 : q64;
        end
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while (!req_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        chk("idle_wait", 64'(req_ready), 64'd1);
    endtask

    // Issue one op, check latency, data and optional stall, then hand-shake
    task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_dir, input logic use_dir, input int hold);
        logic [63:0] exp;
        logic        sp;
        int          lat;
        int          s0;
        exp = ref_model(op, w, a, b, sp);
        if (use_dir) exp = exp_dir;
        wait_idle();
        @(negedge clk);
        s0 = starts_total;
        req_valid = 1'b1; req_op = op; req_word = w; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, "_data"}, resp_data, exp);
        if (sp) begin
            chk({tag, "_lat1"}, 64'(lat), 64'd1);
            chk({tag, "_nostart"}, 64'(starts_total - s0), 64'd0);
        end else begin
            chk({tag, "_latrange"}, 64'(lat >= 60 && lat <= 72), 64'd1);
            chk({tag, "_onestart"}, 64'(starts_total - s0), 64'd1);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, "_hold_data"}, resp_data, exp);
            chk({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        chk({tag, "_hs_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_hs_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;
        int          kind, cyc, guard;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_data", resp_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        run_op("div_m7_2",  2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 0);
        run_op("rem_m7_2",  2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        run_op("divu_b0",   2'b01, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        run_op("remu_b0",   2'b11, 1'b0, 64'h1234, 64'd0, 64'h1234, 1'b1, 0);
        run_op("div_ovf",   2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 0);
        run_op("rem_ovf",   2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
        run_op("divw_ovf",  2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, 0);
        run_op("divw_m7",   2'b00, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 0);
        run_op("divuw",     2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 1'b1, 0);
        run_op("remw_b0",   2'b10, 1'b1, 64'd5, 64'd0, 64'd5, 1'b1, 0);

        // Flush during RUN: divider drains, no response
        wait_idle();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_word = 1'b0; req_a = 64'd1000; req_b = 64'd3;
        @(posedge clk); #1; req_valid = 1'b0;
        cyc = 1;
        repeat (9) begin @(posedge clk); #1; cyc++; end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0; cyc++;
        chk("flush_busy", 64'(busy), 64'd1);
        while (busy && cyc < 100) begin
            chk("flush_novalid", 64'(resp_valid), 64'd0);
            @(posedge clk); #1; cyc++;
        end
        chk("flush_drain_len", 64'(cyc >= 60 && cyc <= 72), 64'd1);
        chk("flush_after_valid", 64'(resp_valid), 64'd0);
        run_op("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1, 0);
        run_op("remu_100_7", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 1'b1, 0);

        // Stalled consumer
        run_op("div_hold", 2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1, 5);

        // Request together with flush is dropped
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; req_a = 64'd9; req_b = 64'd3;
        @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_ready", 64'(req_ready), 64'd1);

        // Flush while a response is waiting in DONE
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_word = 1'b0; req_a = 64'd77; req_b = 64'd0;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("done_valid", 64'(resp_valid), 64'd1);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("done_flush_valid", 64'(resp_valid), 64'd0);
        chk("done_flush_ready", 64'(req_ready), 64'd1);

        // Reset mid-operation
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 64'd12345; req_b = 64'd17;
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_valid", 64'(resp_valid), 64'd0);
        chk("mrst_data", resp_data, 64'd0);
        chk("mrst_ready", 64'(req_ready), 64'd1);
        @(negedge clk); rst = 1'b0;
        run_op("post_rst", 2'b00, 1'b0, 64'd12345, 64'd17, 64'd726, 1'b1, 0);

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            op   = 2'($urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 5);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            case (kind)
                0: b = w ? {$urandom, 32'd0} : 64'd0;
                1: begin
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: b = 64'($urandom_range(1, 20));
                3: b = b >> $urandom_range(0, 63);
                default: ;
            endcase
            run_op("rand", op, w, a, b, 64'd0, 1'b0, 0);
        end

        guard = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_22040127_div_ctrl.md
Name: ysyx_22040127_div_ctrl

Overview:
Sequencing controller between the EX stage and the iterative radix-2 divider ysyx_22040127_div. It accepts one RV64M divide/remainder op at a time, covering DIV/DIVU/REM/REMU and the W forms. It resolves divide-by-zero and signed overflow without starting the divider, and prepares W-form operands. It holds operands stable for the whole divider run, selects and sign-extends the result, and absorbs pipeline flushes by draining the in-flight divide.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  EX presents a divide op
req_ready  out  1  controller can accept; high only in IDLE
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
req_word  in  1  W-form op (DIVW, DIVUW, REMW, REMUW)
req_a  in  64  dividend (rs1)
req_b  in  64  divisor (rs2)
flush  in  1  kill in-flight op; result discarded
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_data  out  64  result
busy  out  1  state != IDLE; drives the EX stall

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; resp_valid=0, resp_data=0, busy=0, req_ready=1 (combinational from IDLE). Internal div_start=0 and the operand registers are cleared. The divider instance shares clk/rst.
- States: IDLE, RUN, DONE, DRAIN.
- Accept is req_valid & req_ready & ~flush. If flush and req_valid are high together, the request is dropped.
- Operand prep at accept, registered:
  - Signed ops with req_word: sign-extend bits [31:0] of each operand.
  - Unsigned ops with req_word: zero-extend bits [31:0] of each operand.
  - Non-word ops: use the operands unchanged.
- Special cases, evaluated on the prepared operands:
  - b==0: quotient = all ones, remainder = a.
  - Signed op with a==most-negative and b==all ones: quotient = a, remainder = 0. For W-forms, most-negative means 0xFFFF_FFFF_8000_0000.
  - Either special case: IDLE->DONE. resp_valid rises the cycle after accept. The divider is never started.
- Normal path: IDLE->RUN. In the first RUN cycle, div_start (the divider's is_div) is high for exactly one cycle.
  - div_x, div_y and div_s stay constant until the divider's ready pulse, because the divider reads the operand signs again at its final step.
  - div_s = ~req_op[0].
- RUN->DONE on the divider's ready pulse. resp_data captures quo when req_op[1]==0, otherwise rem.
- W-forms: resp_data = sign-extension of bit 31 of the selected value. This applies to unsigned W-forms as well.
- DONE: resp_valid=1 and resp_data held stable until resp_valid & resp_ready. At that edge, DONE->IDLE and resp_valid=0.
- No new accept occurs in the same cycle as a response handshake; req_ready stays low in DONE.
- Latency: special cases 1 cycle from accept to resp_valid. Normal ops are 68 cycles; verification checks 60–72 and relies on the ready pulse, not a fixed count.
- Flush handling:
  - IDLE: no effect.
  - RUN: RUN->DRAIN. The divider keeps running, resp_valid stays 0, busy=1.
  - DRAIN: flush is ignored. On the ready pulse, DRAIN->IDLE with no response.
  - DONE: DONE->IDLE, resp_valid=0 next cycle.
- A div_start is never issued while the divider is running. The new div_start always follows the ready pulse by at least one cycle.
- Reset mid-operation: the controller returns to IDLE and the divider is reset alongside it. The bench waits for rst deassertion before issuing requests.

Decomposition:
- Shared package ysyx_22040127_div_pkg holds:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU;
  - state encoding IDLE/RUN/DONE/DRAIN;
  - constant MOST_NEG64 and constant MOST_NEG32_SX.
- Sub-module: the controller instantiates ysyx_22040127_div as the datapath. Special-case detection and operand prep stay inline as combinational logic.

Test Plan:
1. DIV a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2 -> resp_data=0xFFFF_FFFF_FFFF_FFFD within 60–72 cycles. Same operands with REM -> 0xFFFF_FFFF_FFFF_FFFF.
2. DIVU a=0x1234, b=0 -> 0xFFFF_FFFF_FFFF_FFFF one cycle after accept, div_start never asserted. REMU with the same operands -> 0x1234.
3. DIV a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000 in 1 cycle. REM -> 0. DIVW a=0x0000_0000_8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000.
4. W-forms:
   - DIVW a=0x0000_0000_FFFF_FFF9, b=2 -> 0xFFFF_FFFF_FFFF_FFFD.
   - DIVUW a=0xFFFF_FFFF_8000_0000, b=2 -> 0x0000_0000_4000_0000.
   - REMW a=5, b=0 -> 5.
5. Flush at cycle 10 of a DIVU -> no resp_valid, busy stays 1 until the ready pulse. The next DIVU 100/7 returns 14 and REMU returns 2.
6. Hold resp_ready=0 for 5 cycles on a completed DIV 100/7 -> resp_valid=1 and resp_data=14 stable throughout, req_ready=0. After the handshake: IDLE, req_ready=1 next cycle.
